// File: rtl/img_stream_pkg.sv
// Shared constants and fetch-FSM encoding for the output-memory image streamer.
// A line is 16 pixels of 8 bits; the line index is 7 bits, so up to 127 lines per frame.
package img_stream_pkg;

    localparam int PIX_W          = 8;
    localparam int PIX_PER_LINE   = 16;
    localparam int CNT_W          = 4;
    localparam int LINE_IDX_W     = 7;
    localparam int DEF_NUM_LINES  = 64;
    localparam int DEF_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_CAP  = 2'd2,
        F_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/img_line_serializer.sv
// Turns one loaded 128-bit line into 16 registered pixels, LSB byte first.
// A load lands the same cycle the last byte is accepted; pixels hold while i_ready is low.
module img_line_serializer
    import img_stream_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_line,
    input  logic              i_ready,
    output logic [PIX_W-1:0]  o_data,
    output logic              o_valid,
    output logic              o_eol,
    output logic [CNT_W-1:0]  o_byte_cnt,
    output logic              o_free,
    output logic              o_last_accepted
);

    logic [DATA_W-1:0] r_buf;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;

    logic w_accept;
    logic w_last;

    assign w_accept = r_valid & i_ready;
    assign w_last   = w_accept & (r_cnt == CNT_W'(PIX_PER_LINE - 1));

    // The buffer shifts down on each accept so the current pixel is always the low byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_buf   <= i_line;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (w_last) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_buf <= r_buf >> PIX_W;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_data          = r_buf[PIX_W-1:0];
    assign o_valid         = r_valid;
    assign o_eol           = r_valid & (r_cnt == CNT_W'(PIX_PER_LINE - 1));
    assign o_byte_cnt      = r_cnt;
    assign o_free          = ~r_valid | w_last;
    assign o_last_accepted = w_last;

endmodule

// File: rtl/img_out_streamer.sv
// Streams a mapped frame from output memory as 8-bit pixels with one line prefetched; first pixel 5 cycles after start.
// pix_ready low stalls the pixel register, and the fetcher parks in F_HOLD until the prefetch slot frees.
module img_out_streamer
    import img_stream_pkg::*;
#(
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] out_mem_rd_addr,
    input  logic [DATA_W-1:0] out_mem_rd_data,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              stream_done
);

    localparam int WCNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    fetch_state_t           r_state;
    fetch_state_t           w_state_nxt;
    logic [WCNT_W-1:0]      r_wait_cnt;
    logic [LINE_IDX_W-1:0]  r_line_idx;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_next_buf;
    logic                   r_next_valid;
    logic [LINE_IDX_W-1:0]  r_lines_loaded;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_start;
    logic                   w_go_fetch;
    logic                   w_cap;
    logic                   w_wait_inc;
    logic [ADDR_W-1:0]      w_addr_nxt;
    logic                   w_load;
    logic                   w_free;
    logic                   w_last_acc;
    logic                   w_eof_acc;
    logic [CNT_W-1:0]       w_byte_cnt;
    logic                   w_first_line;
    logic                   w_final_line;

    // The done cycle still blocks start so a new frame never overlaps the completion pulse.
    assign w_start = start & ~r_busy & ~r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_go_fetch  = 1'b0;
        w_cap       = 1'b0;
        w_wait_inc  = 1'b0;
        w_addr_nxt  = r_addr;
        case (r_state)
            F_IDLE: begin
                if (w_start) begin
                    w_state_nxt = F_WAIT;
                    w_go_fetch  = 1'b1;
                    w_addr_nxt  = '0;
                end
            end
            F_WAIT: begin
                if (r_wait_cnt == WCNT_W'(RD_LATENCY - 1)) begin
                    w_state_nxt = F_CAP;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            F_CAP: begin
                w_cap       = 1'b1;
                w_state_nxt = F_HOLD;
            end
            F_HOLD: begin
                if (r_line_idx == LINE_IDX_W'(NUM_LINES)) begin
                    w_state_nxt = F_IDLE;
                end else if (!r_next_valid) begin
                    w_state_nxt = F_WAIT;
                    w_go_fetch  = 1'b1;
                    w_addr_nxt  = ADDR_W'(r_line_idx);
                end
            end
            default: w_state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= F_IDLE;
            r_wait_cnt <= '0;
            r_line_idx <= '0;
            r_addr     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            if (w_go_fetch) begin
                r_wait_cnt <= '0;
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            end
            if (w_start) begin
                r_line_idx <= '0;
            end else if (w_cap) begin
                r_line_idx <= r_line_idx + LINE_IDX_W'(1);
            end
        end
    end

    // Capture only happens with the slot empty, so capture and hand-off never collide.
    assign w_load = r_next_valid & w_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_buf   <= '0;
            r_next_valid <= 1'b0;
        end else begin
            if (w_cap) begin
                r_next_buf   <= out_mem_rd_data;
                r_next_valid <= 1'b1;
            end else if (w_load) begin
                r_next_valid <= 1'b0;
            end
        end
    end

    img_line_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk             (clk),
        .reset           (reset),
        .i_load          (w_load),
        .i_line          (r_next_buf),
        .i_ready         (pix_ready),
        .o_data          (pix_data),
        .o_valid         (pix_valid),
        .o_eol           (pix_eol),
        .o_byte_cnt      (w_byte_cnt),
        .o_free          (w_free),
        .o_last_accepted (w_last_acc)
    );

    // r_lines_loaded is the 1-based index of the line now held by the serializer.
    assign w_first_line = (r_lines_loaded == LINE_IDX_W'(1));
    assign w_final_line = (r_lines_loaded == LINE_IDX_W'(NUM_LINES));
    assign w_eof_acc    = w_last_acc & w_final_line;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lines_loaded <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            if (w_start) begin
                r_lines_loaded <= '0;
            end else if (w_load) begin
                r_lines_loaded <= r_lines_loaded + LINE_IDX_W'(1);
            end
            if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_eof_acc) begin
                r_busy <= 1'b0;
            end
            r_done <= w_eof_acc;
        end
    end

    assign out_mem_rd_addr = r_addr;
    assign pix_sof         = pix_valid & w_first_line & (w_byte_cnt == '0);
    assign pix_eof         = pix_valid & w_final_line & (w_byte_cnt == CNT_W'(PIX_PER_LINE - 1));
    assign busy            = r_busy;
    assign stream_done     = r_done;

endmodule

// File: tb/tb_img_out_streamer.sv
// Bench for img_out_streamer: default instance with a 2-cycle memory, plus a 1-line / 1-cycle instance.
module tb_img_out_streamer;

    localparam int NL = 64;
    localparam int RL = 2;
    localparam int AW = 16;
    localparam int DW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, pix_ready;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] rd_data_a;
    logic [7:0]    pix_data_a;
    logic          pix_valid_a, pix_sof_a, pix_eol_a, pix_eof_a, busy_a, stream_done_a;

    logic          start_b, ready_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] rd_data_b;
    logic [7:0]    pix_data_b;
    logic          pix_valid_b, pix_sof_b, pix_eol_b, pix_eof_b, busy_b, stream_done_b;

    img_out_streamer #(.NUM_LINES(NL), .RD_LATENCY(RL), .ADDR_W(AW), .DATA_W(DW)) dut_a (
        .clk(clk), .reset(reset), .start(start),
        .out_mem_rd_addr(addr_a), .out_mem_rd_data(rd_data_a),
        .pix_data(pix_data_a), .pix_valid(pix_valid_a), .pix_ready(pix_ready),
        .pix_sof(pix_sof_a), .pix_eol(pix_eol_a), .pix_eof(pix_eof_a),
        .busy(busy_a), .stream_done(stream_done_a)
    );

    img_out_streamer #(.NUM_LINES(1), .RD_LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .out_mem_rd_addr(addr_b), .out_mem_rd_data(rd_data_b),
        .pix_data(pix_data_b), .pix_valid(pix_valid_b), .pix_ready(ready_b),
        .pix_sof(pix_sof_b), .pix_eol(pix_eol_b), .pix_eof(pix_eof_b),
        .busy(busy_b), .stream_done(stream_done_b)
    );

    function automatic logic [7:0] pat(input int l, input int k);
        return 8'(l * 37 + k * 5 + 3);
    endfunction

    // Memory models: A has a two-stage read pipeline, B a single stage.
    logic [DW-1:0] mem_a [NL];
    logic [DW-1:0] line_b;
    logic [DW-1:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        rd_p1 <= mem_a[addr_a[5:0]];
        rd_p2 <= rd_p1;
        rd_data_b <= (addr_b == 16'd0) ? line_b : '0;
    end
    assign rd_data_a = rd_p2;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eol;
        logic       eof;
    } pix_t;

    pix_t sb_q[$];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        pix_t p;
        for (int l = 0; l < NL; l++) begin
            for (int k = 0; k < 16; k++) begin
                p.d   = pat(l, k);
                p.sof = (l == 0 && k == 0);
                p.eol = (k == 15);
                p.eof = (l == NL - 1 && k == 15);
                sb_q.push_back(p);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ready driver: random or forced level, applied just after each rising edge.
    logic rand_mode = 1'b0;
    logic ready_force = 1'b1;
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor: scoreboard pops, hold-while-stalled, done pulses, address sequence.
    pix_t          mon_cur, mon_prev, mon_exp;
    logic          prev_stall = 1'b0;
    int            done_cnt = 0;
    int            acc_cnt = 0;
    int            addr_run = 0;
    logic [AW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        mon_cur = {pix_data_a, pix_sof_a, pix_eol_a, pix_eof_a};
        if (!reset) begin
            if (prev_stall)
                check("hold_stable", {pix_valid_a, mon_cur}, {1'b1, mon_prev});
            if (pix_valid_a && pix_ready) begin
                check("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    mon_exp = sb_q.pop_front();
                    check("pixel", mon_cur, mon_exp);
                end
                acc_cnt++;
            end
            prev_stall = pix_valid_a && !pix_ready;
            mon_prev   = mon_cur;
            if (stream_done_a) done_cnt++;
            if (addr_a != prev_addr) begin
                check("addr_seq", (addr_a == 0) || (addr_a == prev_addr + 1), 1);
                if (addr_a != 0) check("addr_hold", addr_run >= RL + 1, 1);
                addr_run = 1;
            end else begin
                addr_run++;
            end
            prev_addr = addr_a;
        end else begin
            prev_stall = 1'b0;
        end
    end

    typedef struct {
        int          cyc;
        logic        v;
        logic        sof;
        logic        eol;
        logic        busy;
        logic [7:0]  d;
        logic [15:0] a;
    } vec_t;
    vec_t tab [9];

    task automatic wait_done(input string name, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (stream_done_a) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check(name, got, 1);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    int  vcnt;
    logic got_v;
    logic [7:0] exp_d;
    logic exp_v;

    initial begin
        tab[0] = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00,     16'd0};
        tab[1] = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 8'h00,     16'd0};
        tab[2] = '{3,  1'b0, 1'b0, 1'b0, 1'b1, 8'h00,     16'd0};
        tab[3] = '{4,  1'b0, 1'b0, 1'b0, 1'b1, 8'h00,     16'd0};
        tab[4] = '{5,  1'b1, 1'b1, 1'b0, 1'b1, pat(0, 0),  16'd0};
        tab[5] = '{6,  1'b1, 1'b0, 1'b0, 1'b1, pat(0, 1),  16'd1};
        tab[6] = '{20, 1'b1, 1'b0, 1'b1, 1'b1, pat(0, 15), 16'd1};
        tab[7] = '{21, 1'b1, 1'b0, 1'b0, 1'b1, pat(1, 0),  16'd1};
        tab[8] = '{22, 1'b1, 1'b0, 1'b0, 1'b1, pat(1, 1),  16'd2};

        for (int l = 0; l < NL; l++)
            for (int k = 0; k < 16; k++)
                mem_a[l][8*k +: 8] = pat(l, k);
        for (int k = 0; k < 16; k++)
            line_b[8*k +: 8] = pat(7, k) ^ 8'hA5;

        reset = 1'b1; start = 1'b0; start_b = 1'b0; ready_b = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("reset_a", {pix_valid_a, pix_sof_a, pix_eol_a, pix_eof_a, busy_a, stream_done_a, pix_data_a, addr_a}, 0);
        check("reset_b", {pix_valid_b, pix_sof_b, pix_eol_b, pix_eof_b, busy_b, stream_done_b, pix_data_b, addr_b}, 0);
        step();
        reset = 1'b0;

        // Frame 1: ready held high, startup table, ignored starts at 100 and in the done cycle.
        vcnt = 0;
        for (int c = 0; c <= 1030; c++) begin
            start = (c == 0 || c == 100 || c == 1029);
            if (c == 0) push_frame();
            @(negedge clk);
            for (int t = 0; t < 9; t++)
                if (tab[t].cyc == c)
                    check($sformatf("tab_c%0d", c),
                          {pix_valid_a, pix_sof_a, pix_eol_a, busy_a, pix_data_a, addr_a},
                          {tab[t].v, tab[t].sof, tab[t].eol, tab[t].busy, tab[t].d, tab[t].a});
            if (c >= 5 && c <= 1028 && pix_valid_a) vcnt++;
            if (c == 1028) check("eof_last_pixel", {pix_valid_a, pix_eol_a, pix_eof_a, addr_a}, {3'b111, 16'd63});
            if (c == 1029) check("done_cycle", {stream_done_a, busy_a, pix_valid_a}, 3'b100);
            if (c == 1030) check("done_once_start_ignored", {stream_done_a, busy_a}, 2'b00);
            step();
        end
        start = 1'b0;
        check("no_gaps", vcnt, 1024);
        check("done_count_f1", done_cnt, 1);
        check("sb_drained_f1", sb_q.size(), 0);

        // Frame 2: random backpressure, identical content.
        rand_mode = 1'b1;
        start = 1'b1;
        push_frame();
        step();
        start = 1'b0;
        wait_done("done_seen_f2", 8000);
        rand_mode = 1'b0;
        check("done_count_f2", done_cnt, 2);
        check("sb_drained_f2", sb_q.size(), 0);

        // Frame 3: hold ready low for 40 cycles after first valid.
        ready_force = 1'b0;
        step(); step();
        start = 1'b1;
        push_frame();
        step();
        start = 1'b0;
        got_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_valid_a) begin
                got_v = 1'b1;
                break;
            end
            step();
        end
        check("stall_first_valid", got_v, 1);
        repeat (40) step();
        @(negedge clk);
        check("stall_hold", {pix_valid_a, pix_sof_a, busy_a, pix_data_a, addr_a}, {3'b111, pat(0, 0), 16'd1});
        ready_force = 1'b1;
        wait_done("done_seen_f3", 3000);
        check("done_count_f3", done_cnt, 3);
        check("sb_drained_f3", sb_q.size(), 0);

        // Frame 4: reset around line 10 byte 5, then a clean restart.
        acc_cnt = 0;
        start = 1'b1;
        push_frame();
        step();
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (acc_cnt >= 165) break;
            step();
        end
        check("reached_line10", acc_cnt >= 165, 1);
        step();
        reset = 1'b1;
        @(negedge clk);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_abort", {pix_valid_a, busy_a, stream_done_a, pix_sof_a, pix_eol_a, pix_eof_a, addr_a}, 0);
        sb_q.delete();
        repeat (10) step();
        check("no_done_after_abort", done_cnt, 3);
        start = 1'b1;
        push_frame();
        step();
        start = 1'b0;
        wait_done("done_seen_f5", 3000);
        check("done_count_f5", done_cnt, 4);
        check("sb_drained_f5", sb_q.size(), 0);

        // Single-line instance with one-cycle memory.
        start_b = 1'b1;
        for (int c = 0; c <= 22; c++) begin
            if (c == 1) start_b = 1'b0;
            @(negedge clk);
            exp_v = (c >= 4 && c <= 19);
            exp_d = exp_v ? (pat(7, c - 4) ^ 8'hA5) : 8'h00;
            check($sformatf("b_c%0d", c),
                  {pix_valid_b, pix_sof_b, pix_eol_b, pix_eof_b, stream_done_b, busy_b, pix_valid_b ? pix_data_b : 8'h00},
                  {exp_v, c == 4, c == 19, c == 19, c == 20, c >= 1 && c <= 19, exp_d});
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/img_out_streamer.md
Name: img_out_streamer

Overview:
- Reader-side counterpart of the image mapping controller.
- After `output_wt_done`, reads the mapped image from output memory one 128-bit line at a time and serializes it into an 8-bit pixel stream with valid/ready handshake.
- Carries frame/line markers and signals completion.
- Prefetches one line ahead so lines stream back-to-back without bubbles.

Parameters:
- NUM_LINES, 64, number of 128-bit lines per frame (out_mem addresses 0..NUM_LINES-1)
- RD_LATENCY, 2, cycles from `out_mem_rd_addr` change to valid `out_mem_rd_data`
- ADDR_W, 16, output memory address width
- DATA_W, 128, output memory data width (16 pixels of 8 bits)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse (driven by `output_wt_done`); begins a frame
- out_mem_rd_addr  out  ADDR_W  output memory read address
- out_mem_rd_data  in  DATA_W  output memory read data
- pix_data  out  8  pixel byte
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  downstream accepts pixel when pix_valid && pix_ready
- pix_sof  out  1  qualifies first pixel of frame
- pix_eol  out  1  qualifies last pixel of each line
- pix_eof  out  1  qualifies last pixel of frame
- busy  out  1  frame in progress
- stream_done  out  1  one-cycle pulse after frame end

Behaviour:
- Reset (synchronous, active-high): all outputs 0; fetch and stream engines idle; both line buffers empty. Reset mid-frame aborts immediately; no partial completion pulse.
- Clock is clk; all state updates on posedge clk.
- start is sampled only when busy=0. While busy=1, start is ignored.
- Fetch engine FSM states:
  - F_IDLE: on start, set busy=1, line_idx=0, drive addr=0 → F_WAIT.
  - F_WAIT: count RD_LATENCY cycles with addr held stable → F_CAP.
  - F_CAP: load out_mem_rd_data into next_buf; set next_valid=1; line_idx++ → F_HOLD.
  - F_HOLD: when next_valid=0 and line_idx<NUM_LINES, drive addr=line_idx → F_WAIT. When line_idx==NUM_LINES → F_IDLE (fetch finished).
- Address rule: out_mem_rd_addr = zero-extended line_idx. It holds its last value when not fetching.
- Stream engine:
  - Holds cur_buf, cur_valid and a 4-bit byte_cnt.
  - Pixel k of a line is cur_buf[8k+7:8k], k=0..15, LSB byte first.
  - pix_data/pix_valid are registered outputs.
  - Once pix_valid=1, pix_data and flags stay stable until accepted (no retraction).
- Line transfer:
  - When cur_valid=0, or the last byte of cur is accepted this cycle, and next_valid=1: cur_buf<=next_buf, next_valid<=0, byte_cnt<=0.
  - Consequence: no idle cycle between lines when prefetch is ready.
- Flags:
  - pix_sof = (line 0, byte 0).
  - pix_eol = (byte_cnt==15).
  - pix_eof = (last line, byte 15).
- Completion: on acceptance of the eof pixel, the next cycle has pix_valid=0, busy=0, stream_done=1 for exactly one cycle. A start in that cycle is ignored; start is accepted from the following cycle.
- Latency with default parameters, counting from start high in cycle 0:
  - addr=0 in cycle 1
  - data captured end of cycle 3
  - next_valid in cycle 4
  - first pix_valid in cycle 5
- Backpressure:
  - pix_ready=0 stalls the stream; byte_cnt holds.
  - Fetch stalls in F_HOLD while next_valid=1.
  - No memory reads are lost or repeated.
- Width: line_idx is 7 bits, compared against NUM_LINES; no wrap within a frame. Total pixels per frame = 16*NUM_LINES.

Decomposition:
- Package img_stream_pkg holds:
  - constants PIX_W=8, PIX_PER_LINE=16, default NUM_LINES and RD_LATENCY
  - fetch FSM state encodings F_IDLE, F_WAIT, F_CAP, F_HOLD
- Sub-module img_line_serializer: cur_buf, byte_cnt, valid/ready output register and eol flag. Takes a load strobe plus 128-bit line; reports last_accepted.
- Top level holds the fetch FSM, next_buf, and the sof/eof/done logic.

Test Plan:
- Full frame, pix_ready=1, mem[i]=per-byte pattern {i,k}: start at cycle 0 → first pix_valid at cycle 5 with pix_data=mem[0][7:0] and pix_sof=1; 1024 pixels in order; no gaps between lines; eof on pixel 1023; stream_done one cycle later.
- Random pix_ready (50%): same 1024-byte sequence; pix_data stable while valid&&!ready; each address 0..63 presented exactly once, held ≥RD_LATENCY cycles.
- pix_ready=0 for 40 cycles after first valid: pix_valid stays 1 with data=mem[0][7:0]; next_buf holds line 1; addr stays 1 (no fetch of line 2).
- start pulsed during busy at cycle 100: ignored; one stream_done total; second start after done → second full frame identical.
- Reset asserted mid-frame (line 10, byte 5): next cycle pix_valid=0, busy=0, addr=0, stream_done never pulses; subsequent start streams from line 0 with sof.
- NUM_LINES=1, RD_LATENCY=1: 16 pixels; pixel 15 has eol=eof=1; first valid at cycle 4.
